// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encoding, control-byte values
// and a helper that places the two control bytes at the top of a word of any width.
package cpu_loader_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned MAX_WORD_W = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ASSEMBLE,
      ST_DECODE,
      ST_WRITE,
      ST_RELEASE
   } state_e;

   localparam logic [BYTE_W-1:0] CTRL_HI   = 8'hFF;
   localparam logic [BYTE_W-1:0] CTRL_NONE = 8'h00;
   localparam logic [BYTE_W-1:0] CTRL_RST  = 8'hFF;
   localparam logic [BYTE_W-1:0] CTRL_KEEP = 8'hF0;

   // Top byte CTRL_HI, next byte sub, remaining bytes zero; caller truncates to word_w.
   function automatic logic [MAX_WORD_W-1:0] ctrl_word(input int unsigned word_w,
                                                       input logic [BYTE_W-1:0] sub);
      logic [MAX_WORD_W-1:0] w;
      w = (MAX_WORD_W'(CTRL_HI) << (word_w - BYTE_W)) |
          (MAX_WORD_W'(sub) << (word_w - 2 * BYTE_W));
      return w;
   endfunction

endpackage

// File: rtl/loader_byte_packer.sv
// UART byte intake: 4-phase ready/ack handshake, little-endian packing into a word,
// and inter-byte timeout that drops a partially assembled word.
module loader_byte_packer
   import cpu_loader_pkg::*;
#(
   parameter int unsigned WORD_BYTES  = 3,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         accept_en_i,
   input  logic                         packet_ready_i,
   input  logic [BYTE_W-1:0]            uart_packet_i,
   output logic                         packet_ack_o,
   output logic [BYTE_W*WORD_BYTES-1:0] word_o,
   output logic                         byte_acc_c,
   output logic                         word_done_c,
   output logic                         timeout_c
);

   localparam int unsigned WORD_W = BYTE_W * WORD_BYTES;
   localparam int unsigned CNT_W  = $clog2(WORD_BYTES + 1);
   localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

   logic              ack_q, ack_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              last_c;
   logic [CNT_W+2:0]  shamt_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q  <= 1'b0;
         cnt_q  <= '0;
         word_q <= '0;
         tmo_q  <= '0;
      end else begin
         ack_q  <= ack_d;
         cnt_q  <= cnt_d;
         word_q <= word_d;
         tmo_q  <= tmo_d;
      end
   end

   always_comb begin
      ack_d       = ack_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      tmo_d       = tmo_q;
      timeout_c   = 1'b0;
      shamt_c     = {cnt_q, 3'b000};
      byte_acc_c  = accept_en_i && packet_ready_i && !ack_q;
      last_c      = (cnt_q == CNT_W'(WORD_BYTES - 1));
      word_done_c = byte_acc_c && last_c;

      if (byte_acc_c) begin
         ack_d = 1'b1;
      end else if (ack_q && !packet_ready_i) begin
         ack_d = 1'b0;
      end

      // Timer only runs while a partial word is held; a new byte restarts it.
      if (byte_acc_c) begin
         word_d = (word_q & ~(WORD_W'(8'hFF) << shamt_c)) | (WORD_W'(uart_packet_i) << shamt_c);
         cnt_d  = last_c ? '0 : cnt_q + CNT_W'(1);
         tmo_d  = '0;
      end else if (cnt_q != '0) begin
         if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            timeout_c = 1'b1;
            cnt_d     = '0;
            tmo_d     = '0;
         end else begin
            tmo_d = tmo_q + TMO_W'(1);
         end
      end else begin
         tmo_d = '0;
      end
   end

   assign packet_ack_o = ack_q;
   assign word_o       = word_q;

endmodule

// File: rtl/cpu_program_loader.sv
// Loads a program from UART bytes into instruction RAM: START/END control words open and
// close a session that pauses the CPU, with overflow/timeout reporting and a word counter.
module cpu_program_loader
   import cpu_loader_pkg::*;
#(
   parameter int unsigned WORD_BYTES  = 3,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         halt_flag,
   input  logic                         packet_ready,
   input  logic [7:0]                   uart_packet,
   input  logic                         mem_ack,
   input  logic [ADDR_W-1:0]            pc_addr,
   output logic                         packet_ack,
   output logic                         cpu_paused,
   output logic                         reset_pc,
   output logic                         mem_we,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [BYTE_W*WORD_BYTES-1:0] mem_wdata,
   output logic [ADDR_W:0]              words_loaded,
   output logic                         load_error
);

   localparam int unsigned WORD_W = BYTE_W * WORD_BYTES;
   localparam int unsigned WL_W   = ADDR_W + 1;

   localparam logic [WORD_W-1:0] W_START    = WORD_W'(ctrl_word(WORD_W, CTRL_NONE));
   localparam logic [WORD_W-1:0] W_END_RST  = WORD_W'(ctrl_word(WORD_W, CTRL_RST));
   localparam logic [WORD_W-1:0] W_END_KEEP = WORD_W'(ctrl_word(WORD_W, CTRL_KEEP));
   localparam logic [WL_W-1:0]   DEPTH      = {1'b1, {ADDR_W{1'b0}}};

   state_e              state_q, state_d;
   logic                session_q, session_d;
   logic                paused_q, paused_d;
   logic                rst_pc_q, rst_pc_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic [WL_W-1:0]     wl_q, wl_d;
   logic                err_q, err_d;

   logic                accept_en_c;
   logic [WORD_W-1:0]   word_c;
   logic                byte_acc_c;
   logic                word_done_c;
   logic                timeout_c;

   assign accept_en_c = (state_q == ST_IDLE) || (state_q == ST_ASSEMBLE);

   loader_byte_packer #(
      .WORD_BYTES  (WORD_BYTES),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_packer (
      .clk            (clk),
      .rst            (rst),
      .accept_en_i    (accept_en_c),
      .packet_ready_i (packet_ready),
      .uart_packet_i  (uart_packet),
      .packet_ack_o   (packet_ack),
      .word_o         (word_c),
      .byte_acc_c     (byte_acc_c),
      .word_done_c    (word_done_c),
      .timeout_c      (timeout_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         session_q <= 1'b0;
         paused_q  <= 1'b0;
         rst_pc_q  <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wl_q      <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         session_q <= session_d;
         paused_q  <= paused_d;
         rst_pc_q  <= rst_pc_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wl_q      <= wl_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      session_d = session_q;
      paused_d  = paused_q;
      rst_pc_d  = rst_pc_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wl_d      = wl_q;
      err_d     = err_q;

      case (state_q)
         ST_IDLE: begin
            if (word_done_c) begin
               state_d = ST_DECODE;
            end else if (byte_acc_c) begin
               state_d = ST_ASSEMBLE;
            end
         end
         ST_ASSEMBLE: begin
            if (word_done_c) begin
               state_d = ST_DECODE;
            end else if (timeout_c) begin
               state_d = ST_IDLE;
               if (session_q) begin
                  err_d = 1'b1;
               end
            end
         end
         ST_DECODE: begin
            state_d = ST_IDLE;
            if (word_c == W_START) begin
               if (halt_flag) begin
                  session_d = 1'b1;
                  paused_d  = 1'b1;
                  addr_d    = '0;
                  wl_d      = '0;
                  err_d     = 1'b0;
               end
            end else if (word_c == W_END_RST) begin
               if (session_q) begin
                  rst_pc_d = 1'b1;
                  state_d  = ST_RELEASE;
               end
            end else if (word_c == W_END_KEEP) begin
               if (session_q) begin
                  paused_d = 1'b0;
                  state_d  = ST_RELEASE;
               end
            end else if (session_q) begin
               if (wl_q == DEPTH) begin
                  err_d = 1'b1;
               end else begin
                  wdata_d = word_c;
                  we_d    = 1'b1;
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            if (we_q && mem_ack) begin
               we_d    = 1'b0;
               addr_d  = addr_q + ADDR_W'(1);
               wl_d    = wl_q + WL_W'(1);
               state_d = ST_IDLE;
            end
         end
         ST_RELEASE: begin
            // PC-reset path waits for the CPU to confirm PC == 0 before letting go.
            if (rst_pc_q) begin
               if (pc_addr == '0) begin
                  rst_pc_d = 1'b0;
                  paused_d = 1'b0;
               end
            end else begin
               state_d   = ST_IDLE;
               addr_d    = '0;
               session_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cpu_paused   = paused_q;
   assign reset_pc     = rst_pc_q;
   assign mem_we       = we_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign words_loaded = wl_q;
   assign load_error   = err_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Scoreboard bench for cpu_program_loader: a session-level model queues expected RAM writes,
// a monitor checks each acknowledged write, and directed plus random word streams are applied.
module tb_cpu_program_loader;

   localparam int unsigned WB    = 3;
   localparam int unsigned AW    = 2;
   localparam int unsigned TMO   = 40;
   localparam int unsigned DEPTH = 1 << AW;

   localparam logic [23:0] W_START    = 24'hFF0000;
   localparam logic [23:0] W_END_RST  = 24'hFFFF00;
   localparam logic [23:0] W_END_KEEP = 24'hFFF000;

   typedef struct {
      logic [AW-1:0] addr;
      logic [23:0]   data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          halt_flag;
   logic          packet_ready;
   logic [7:0]    uart_packet;
   logic          mem_ack;
   logic [AW-1:0] pc_addr;
   logic          packet_ack;
   logic          cpu_paused;
   logic          reset_pc;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [23:0]   mem_wdata;
   logic [AW:0]   words_loaded;
   logic          load_error;

   int  checks = 0;
   int  errors = 0;
   wr_t exp_q[$];
   bit  saw_rpc;
   int  ack_wait;

   // Behavioural session model
   bit m_session, m_paused, m_err;
   int m_addr, m_count;

   cpu_program_loader #(
      .WORD_BYTES  (WB),
      .ADDR_W      (AW),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .halt_flag    (halt_flag),
      .packet_ready (packet_ready),
      .uart_packet  (uart_packet),
      .mem_ack      (mem_ack),
      .pc_addr      (pc_addr),
      .packet_ack   (packet_ack),
      .cpu_paused   (cpu_paused),
      .reset_pc     (reset_pc),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .words_loaded (words_loaded),
      .load_error   (load_error)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      m_session = 0; m_paused = 0; m_err = 0; m_addr = 0; m_count = 0;
   endtask

   task automatic model_word(input logic [23:0] w);
      if (w == W_START) begin
         if (halt_flag) begin
            m_session = 1; m_paused = 1; m_addr = 0; m_count = 0; m_err = 0;
         end
      end else if (w == W_END_RST || w == W_END_KEEP) begin
         if (m_session) begin
            m_session = 0; m_paused = 0; m_addr = 0;
         end
      end else if (m_session) begin
         if (m_count == DEPTH) begin
            m_err = 1;
         end else begin
            exp_q.push_back('{addr: AW'(m_addr), data: w});
            m_addr  = (m_addr + 1) % DEPTH;
            m_count = m_count + 1;
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      packet_ready = 1'b1;
      uart_packet  = b;
      n = 0;
      while (packet_ack !== 1'b1 && n < 200) begin tick(); n++; end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL ack_rise: got %0b expected 1", packet_ack);
      end
      packet_ready = 1'b0;
      n = 0;
      while (packet_ack !== 1'b0 && n < 200) begin tick(); n++; end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL ack_fall: got %0b expected 0", packet_ack);
      end
   endtask

   task automatic send_word(input logic [23:0] w);
      logic [23:0] v;
      v = w;
      model_word(v);
      for (int i = 0; i < 3; i++) send_byte(v[8*i +: 8]);
   endtask

   task automatic settle();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL write_missing: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (5) tick();
   endtask

   task automatic check_state(input string tag);
      check({tag, ".cpu_paused"},   32'(cpu_paused),   32'(m_paused));
      check({tag, ".load_error"},   32'(load_error),   32'(m_err));
      check({tag, ".words_loaded"}, 32'(words_loaded), 32'(m_count));
      check({tag, ".mem_addr"},     32'(mem_addr),     32'(m_addr));
      check({tag, ".reset_pc"},     32'(reset_pc),     32'h0);
   endtask

   function automatic logic [23:0] rand_data();
      logic [23:0] w;
      w = 24'($urandom);
      if (w[23:16] == 8'hFF) w[23:16] = 8'h7F;
      return w;
   endfunction

   // RAM side: acknowledge each write after a random delay.
   initial begin
      mem_ack  = 1'b0;
      ack_wait = 3;
      forever begin
         @(posedge clk);
         #1;
         if (mem_ack) begin
            mem_ack  = 1'b0;
            ack_wait = $urandom_range(0, 4);
         end else if (mem_we && !rst) begin
            if (ack_wait == 0) mem_ack = 1'b1;
            else ack_wait--;
         end
      end
   end

   // Monitor: a write completes on the edge where mem_we and mem_ack are both high.
   always @(negedge clk) begin
      if (!rst && mem_we && mem_ack) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (mem_addr !== e.addr || mem_wdata !== e.data) begin
               errors++;
               $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                        mem_addr, mem_wdata, e.addr, e.data);
            end
         end
      end
      if (reset_pc) saw_rpc = 1'b1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; halt_flag = 1'b0; packet_ready = 1'b0; uart_packet = 8'h00;
      pc_addr = '0; saw_rpc = 1'b0;
      model_reset();
      repeat (4) tick();
      check("rst.packet_ack", 32'(packet_ack), 32'h0);
      check("rst.mem_we",     32'(mem_we),     32'h0);
      check("rst.mem_wdata",  32'(mem_wdata),  32'h0);
      check_state("rst");
      rst = 1'b0;
      tick();

      // START with CPU halted
      halt_flag = 1'b1;
      send_word(W_START);
      settle();
      check_state("start");

      // three program words
      send_word(24'h123456);
      send_word(24'hABCDEF);
      send_word(24'h000001);
      settle();
      check_state("data3");

      // END_RST: hold until PC reads zero
      pc_addr = 2'd3;
      send_word(W_END_RST);
      tick();
      check("endrst.reset_pc_hold", 32'(reset_pc), 32'h1);
      check("endrst.paused_hold", 32'(cpu_paused), 32'h1);
      repeat (9) tick();
      check("endrst.reset_pc_hold10", 32'(reset_pc), 32'h1);
      pc_addr = '0;
      settle();
      check_state("endrst");

      // START ignored while CPU running
      halt_flag = 1'b0;
      send_word(W_START);
      send_word(rand_data());
      settle();
      check_state("nohalt");

      // partial word timeout inside a session
      halt_flag = 1'b1;
      send_word(W_START);
      send_word(rand_data());
      settle();
      send_byte(8'h11);
      send_byte(8'h22);
      if (m_session) m_err = 1;
      repeat (TMO + 10) tick();
      check_state("timeout");
      send_word(24'h00C0DE);
      settle();
      check_state("after_timeout");

      // overflow: DEPTH+1 data words, then END_KEEP
      send_word(W_START);
      for (int i = 0; i < DEPTH + 1; i++) send_word(rand_data());
      settle();
      check_state("overflow");
      saw_rpc = 1'b0;
      send_word(W_END_KEEP);
      settle();
      check_state("endkeep");
      check("endkeep.saw_reset_pc", 32'(saw_rpc), 32'h0);

      // reset in the middle of a session
      send_word(W_START);
      settle();
      check("midrst.paused_before", 32'(cpu_paused), 32'h1);
      rst = 1'b1;
      tick();
      check("midrst.paused", 32'(cpu_paused), 32'h0);
      check("midrst.reset_pc", 32'(reset_pc), 32'h0);
      rst = 1'b0;
      model_reset();
      tick();

      // randomized word stream
      for (int it = 0; it < 40; it++) begin
         int kind;
         halt_flag = 1'($urandom_range(0, 1));
         kind = $urandom_range(0, 9);
         case (kind)
            0, 1: send_word(W_START);
            2:    send_word(W_END_RST);
            3:    send_word(W_END_KEEP);
            default: send_word(rand_data());
         endcase
         settle();
         check_state("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
